// File: rtl/wishbone_arbiter_2m_pkg.sv
// Shared types for the two-master Wishbone arbiter: FSM state encoding and grant codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_arb_pkg;

  // GNT0/GNT1 share their low bits with the one-hot grant codes below.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT0  = 2'b01,
    GNT1  = 2'b10,
    FLUSH = 2'b11
  } arb_state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/wishbone_arbiter_2m_if.sv
// One Wishbone classic bus segment: request signals from a master, response signals back.
// Latency: n/a (wires only).
// Backpressure: the slave holds ack low until it can complete the transfer.
interface wishbone_arbiter_2m_if;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic        ack;
  logic [31:0] dat_r;
  logic        irq;

  // Side that issues transfers.
  modport master (
    output we, cyc, stb, sel, adr, dat_w,
    input  ack, dat_r, irq
  );

  // Side that answers transfers.
  modport slave (
    input  we, cyc, stb, sel, adr, dat_w,
    output ack, dat_r, irq
  );
endinterface

// File: rtl/wishbone_arbiter_2m_watchdog.sv
// Stall watchdog: counts granted stb cycles without ack and fires on the TIMEOUT-th one.
// Latency: fire is combinational in the stalled cycle where the count equals TIMEOUT-1.
// Backpressure: none; an ack in the firing cycle suppresses fire (ack wins).
module wb_arb_watchdog #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic ack,
  output logic fire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  // Count stalled cycles; clear on ack or when not stalling; saturate at LAST, never wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!enable || ack) begin
      cnt_q <= '0;
    end else if (cnt_q != LAST) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign fire = enable && !ack && (cnt_q == LAST);

endmodule

// File: rtl/wishbone_arbiter_2m.sv
// Two-master Wishbone arbiter: round-robin grant held for the whole cyc burst, watchdog reclaims a stalled bus.
// Latency: grant is registered (request in t, slave cyc in t+1); data/ack paths are combinational while granted.
// Backpressure: the waiting master sees ack low until granted; nothing is buffered.
module wishbone_arbiter_2m
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  wishbone_arbiter_2m_if.slave  m0,
  wishbone_arbiter_2m_if.slave  m1,
  wishbone_arbiter_2m_if.master s,
  output logic                  o_timeout,
  output logic [1:0]            o_grant
);

  arb_state_t state_q, state_d;
  logic       last_grant_q, last_grant_d;   // 0: master 0 was served last, 1: master 1
  logic [1:0] mask_q, mask_d;
  logic       req0, req1;
  logic       wd_enable, wd_fire;

  assign req0 = m0.cyc && !mask_q[0];
  assign req1 = m1.cyc && !mask_q[1];

  // cyc is part of the enable so a master releasing the bus with stb still up
  // clears the count before the bus is handed to the other master.
  assign wd_enable = ((state_q == GNT0) && m0.cyc && m0.stb) ||
                     ((state_q == GNT1) && m1.cyc && m1.stb);

  wb_arb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .enable (wd_enable),
    .ack    (s.ack),
    .fire   (wd_fire)
  );

  assign o_timeout = wd_fire;

  // State, round-robin pointer and timeout masks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      mask_q       <= 2'b00;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mask_q       <= mask_d;
    end
  end

  // Arbitration, burst hold, direct handoff and watchdog-driven flush.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mask_d       = mask_q;
    if (!m0.cyc) mask_d[0] = 1'b0;
    if (!m1.cyc) mask_d[1] = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 && req1)  state_d = last_grant_q ? GNT0 : GNT1;
        else if (req0)     state_d = GNT0;
        else if (req1)     state_d = GNT1;
      end
      GNT0: begin
        if (wd_fire) begin
          mask_d[0] = 1'b1;
          state_d   = FLUSH;
        end else if (!m0.cyc) begin
          last_grant_d = 1'b0;
          state_d      = req1 ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (wd_fire) begin
          mask_d[1] = 1'b1;
          state_d   = FLUSH;
        end else if (!m1.cyc) begin
          last_grant_d = 1'b1;
          state_d      = req0 ? GNT0 : IDLE;
        end
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant indication straight from the registered state.
  always_comb begin
    o_grant = GNT_NONE;
    case (state_q)
      GNT0:    o_grant = GNT_M0;
      GNT1:    o_grant = GNT_M1;
      default: o_grant = GNT_NONE;
    endcase
  end

  // Bus mux: granted master drives the slave port and sees its response; everything else is zero.
  always_comb begin
    s.we     = 1'b0;
    s.cyc    = 1'b0;
    s.stb    = 1'b0;
    s.sel    = 4'h0;
    s.adr    = 32'h0;
    s.dat_w  = 32'h0;
    m0.ack   = 1'b0;
    m0.dat_r = 32'h0;
    m1.ack   = 1'b0;
    m1.dat_r = 32'h0;
    case (state_q)
      GNT0: begin
        s.we     = m0.we;
        s.cyc    = m0.cyc;
        s.stb    = m0.stb;
        s.sel    = m0.sel;
        s.adr    = m0.adr;
        s.dat_w  = m0.dat_w;
        m0.ack   = s.ack;
        m0.dat_r = s.dat_r;
      end
      GNT1: begin
        s.we     = m1.we;
        s.cyc    = m1.cyc;
        s.stb    = m1.stb;
        s.sel    = m1.sel;
        s.adr    = m1.adr;
        s.dat_w  = m1.dat_w;
        m1.ack   = s.ack;
        m1.dat_r = s.dat_r;
      end
      default: ;
    endcase
  end

  assign m0.irq = s.irq;
  assign m1.irq = s.irq;

endmodule

// File: tb/tb_wishbone_arbiter_2m.sv
// Directed bench for the two-master arbiter with per-master request and read-data scoreboards.
// Latency: inputs driven and outputs sampled on the falling edge, DUT state changes on the rising edge.
// Backpressure: the bench plays the slave and chooses when to ack.
module tb_wishbone_arbiter_2m;
  import wb_arb_pkg::*;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
  } req_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       o_timeout;
  logic [1:0] o_grant;

  int checks = 0;
  int errors = 0;

  req_t        req_q0[$];
  req_t        req_q1[$];
  logic [31:0] rd_q[$];

  wishbone_arbiter_2m_if m0_bus ();
  wishbone_arbiter_2m_if m1_bus ();
  wishbone_arbiter_2m_if s_bus ();

  wishbone_arbiter_2m #(
    .TIMEOUT (8),
    .CNT_W   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m0        (m0_bus),
    .m1        (m1_bus),
    .s         (s_bus),
    .o_timeout (o_timeout),
    .o_grant   (o_grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step_cyc();
    @(negedge clk);
  endtask

  task automatic drive(input int m, input logic c, input logic w, input logic [3:0] se,
                       input logic [31:0] a, input logic [31:0] d);
    if (m == 0) begin
      m0_bus.cyc = c; m0_bus.stb = c; m0_bus.we = w;
      m0_bus.sel = se; m0_bus.adr = a; m0_bus.dat_w = d;
    end else begin
      m1_bus.cyc = c; m1_bus.stb = c; m1_bus.we = w;
      m1_bus.sel = se; m1_bus.adr = a; m1_bus.dat_w = d;
    end
  endtask

  task automatic start(input int m, input logic w, input logic [3:0] se,
                       input logic [31:0] a, input logic [31:0] d);
    req_t r;
    drive(m, 1'b1, w, se, a, d);
    r.adr = a; r.dat = d; r.we = w; r.sel = se;
    if (m == 0) req_q0.push_back(r);
    else        req_q1.push_back(r);
  endtask

  task automatic drop(input int m);
    drive(m, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic idle_slave();
    s_bus.ack   = 1'b0;
    s_bus.dat_r = 32'h0;
  endtask

  // Slave acks the current beat; compare what reached the slave and what reached the master.
  task automatic ack_beat(input int m, input logic [31:0] rd, input string tag);
    req_t        e;
    logic [31:0] er;
    int          n;
    s_bus.ack   = 1'b1;
    s_bus.dat_r = rd;
    rd_q.push_back(rd);
    #1;
    n = (m == 0) ? req_q0.size() : req_q1.size();
    chk({tag, "_sbdepth"}, 32'(n > 0), 32'd1);
    e  = '0;
    if (n > 0) begin
      if (m == 0) e = req_q0.pop_front();
      else        e = req_q1.pop_front();
    end
    er = rd_q.pop_front();
    chk({tag, "_cyc"}, 32'(s_bus.cyc), 32'd1);
    chk({tag, "_adr"}, s_bus.adr, e.adr);
    chk({tag, "_datw"}, s_bus.dat_w, e.dat);
    chk({tag, "_we"}, 32'(s_bus.we), 32'(e.we));
    chk({tag, "_sel"}, 32'(s_bus.sel), 32'(e.sel));
    chk({tag, "_timeout"}, 32'(o_timeout), 32'd0);
    if (m == 0) begin
      chk({tag, "_m0ack"}, 32'(m0_bus.ack), 32'd1);
      chk({tag, "_m0dat"}, m0_bus.dat_r, er);
      chk({tag, "_m1ack"}, 32'(m1_bus.ack), 32'd0);
      chk({tag, "_m1dat"}, m1_bus.dat_r, 32'h0);
    end else begin
      chk({tag, "_m1ack"}, 32'(m1_bus.ack), 32'd1);
      chk({tag, "_m1dat"}, m1_bus.dat_r, er);
      chk({tag, "_m0ack"}, 32'(m0_bus.ack), 32'd0);
      chk({tag, "_m0dat"}, m0_bus.dat_r, 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst = 1'b1;
    drop(0);
    drop(1);
    idle_slave();
    s_bus.irq = 1'b0;
    #12;
    chk("rst_grant", 32'(o_grant), 32'(GNT_NONE));
    chk("rst_scyc", 32'(s_bus.cyc), 32'd0);
    chk("rst_sadr", s_bus.adr, 32'h0);
    chk("rst_timeout", 32'(o_timeout), 32'd0);
    chk("rst_m0ack", 32'(m0_bus.ack), 32'd0);
    chk("rst_m1dat", m1_bus.dat_r, 32'h0);
    step_cyc();
    rst = 1'b0;
    step_cyc();

    // Simultaneous request right after reset: m0 first, m1 handed over with no idle gap.
    start(0, 1'b0, 4'hF, 32'h0000_1000, 32'h0);
    start(1, 1'b1, 4'h3, 32'h0000_2000, 32'hCAFE_0001);
    #1;
    chk("simul_idle", 32'(o_grant), 32'(GNT_NONE));
    step_cyc();
    chk("simul_g0", 32'(o_grant), 32'(GNT_M0));
    ack_beat(0, 32'h1111_2222, "simul_m0");
    step_cyc();
    idle_slave();
    drop(0);
    #1;
    chk("simul_hold", 32'(o_grant), 32'(GNT_M0));
    chk("simul_m1wait", 32'(m1_bus.ack), 32'd0);
    step_cyc();
    chk("simul_g1", 32'(o_grant), 32'(GNT_M1));
    ack_beat(1, 32'h3333_4444, "simul_m1");
    step_cyc();
    idle_slave();
    drop(1);
    step_cyc();
    chk("simul_end", 32'(o_grant), 32'(GNT_NONE));

    // Fairness: both request continuously, 2-beat bursts, grant must alternate.
    start(0, 1'b1, 4'hF, 32'h0000_0100, 32'h0000_00A0);
    start(1, 1'b1, 4'hC, 32'h0000_0200, 32'h0000_00B0);
    step_cyc();
    for (int b = 0; b < 4; b++) begin
      int m;
      m = b % 2;
      chk($sformatf("fair_grant%0d", b), 32'(o_grant), (m == 1) ? 32'(GNT_M1) : 32'(GNT_M0));
      ack_beat(m, 32'h5000_0000 + b, "fair_b1");
      step_cyc();
      idle_slave();
      start(m, 1'b1, 4'hF, 32'h0000_0300 + b, 32'h0000_00C0 + b);
      ack_beat(m, 32'h6000_0000 + b, "fair_b2");
      step_cyc();
      idle_slave();
      drop(m);
      step_cyc();
      if (b < 2) start(m, 1'b0, 4'hF, 32'h0000_0400 + b, 32'h0000_00D0 + b);
    end
    chk("fair_end", 32'(o_grant), 32'(GNT_NONE));

    // Single master write, slave acks on the third granted cycle.
    start(0, 1'b1, 4'hF, 32'h0100_0004, 32'hDEAD_BEEF);
    #1;
    chk("single_lat_cyc", 32'(s_bus.cyc), 32'd0);
    step_cyc();
    chk("single_cyc", 32'(s_bus.cyc), 32'd1);
    chk("single_grant", 32'(o_grant), 32'(GNT_M0));
    chk("single_adr", s_bus.adr, 32'h0100_0004);
    chk("single_noack1", 32'(m0_bus.ack), 32'd0);
    step_cyc();
    chk("single_noack2", 32'(m0_bus.ack), 32'd0);
    step_cyc();
    ack_beat(0, 32'h0, "single");
    step_cyc();
    idle_slave();
    drop(0);
    #1;
    chk("single_ackdrop", 32'(m0_bus.ack), 32'd0);
    step_cyc();
    chk("single_end", 32'(o_grant), 32'(GNT_NONE));

    // Timeout: m1 stalls forever, m0 waits; m1 masked until it drops cyc.
    drive(1, 1'b1, 1'b1, 4'hF, 32'h0BAD_0000, 32'h1);
    step_cyc();
    start(0, 1'b0, 4'hF, 32'h0000_3000, 32'h0);
    for (int c = 1; c <= 8; c++) begin
      #1;
      chk($sformatf("to_pulse%0d", c), 32'(o_timeout), 32'(c == 8));
      chk($sformatf("to_cyc%0d", c), 32'(s_bus.cyc), 32'd1);
      chk($sformatf("to_m1ack%0d", c), 32'(m1_bus.ack), 32'd0);
      if (c < 8) step_cyc();
    end
    step_cyc();
    chk("to_flush_cyc", 32'(s_bus.cyc), 32'd0);
    chk("to_flush_adr", s_bus.adr, 32'h0);
    chk("to_flush_grant", 32'(o_grant), 32'(GNT_NONE));
    chk("to_flush_pulse", 32'(o_timeout), 32'd0);
    step_cyc();
    chk("to_idle", 32'(o_grant), 32'(GNT_NONE));
    step_cyc();
    chk("to_m0_grant", 32'(o_grant), 32'(GNT_M0));
    ack_beat(0, 32'h7777_8888, "to_m0");
    step_cyc();
    idle_slave();
    drop(0);
    step_cyc();
    chk("to_m1_masked_a", 32'(o_grant), 32'(GNT_NONE));
    step_cyc();
    chk("to_m1_masked_b", 32'(o_grant), 32'(GNT_NONE));
    drop(1);
    step_cyc();
    start(1, 1'b1, 4'hF, 32'h0000_4000, 32'h0000_0044);
    step_cyc();
    chk("to_m1_regrant", 32'(o_grant), 32'(GNT_M1));
    ack_beat(1, 32'h0, "to_m1");
    step_cyc();
    idle_slave();
    drop(1);
    step_cyc();
    chk("to_end", 32'(o_grant), 32'(GNT_NONE));

    // Ack on the boundary: ack arrives on the 8th stalled cycle and wins.
    start(1, 1'b0, 4'h5, 32'h0000_5000, 32'h0);
    step_cyc();
    for (int c = 1; c <= 7; c++) begin
      #1;
      chk($sformatf("bnd_nopulse%0d", c), 32'(o_timeout), 32'd0);
      step_cyc();
    end
    ack_beat(1, 32'hB0B0_CAFE, "bnd");
    step_cyc();
    idle_slave();
    drop(1);
    step_cyc();
    chk("bnd_end", 32'(o_grant), 32'(GNT_NONE));

    // Asynchronous reset in the middle of a GNT0 read, then interrupt broadcast.
    start(0, 1'b0, 4'hF, 32'h0000_6000, 32'h0);
    step_cyc();
    chk("ar_grant", 32'(o_grant), 32'(GNT_M0));
    s_bus.ack   = 1'b1;
    s_bus.dat_r = 32'h1234_5678;
    #1;
    chk("ar_preack", 32'(m0_bus.ack), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_grant0", 32'(o_grant), 32'(GNT_NONE));
    chk("ar_scyc", 32'(s_bus.cyc), 32'd0);
    chk("ar_sstb", 32'(s_bus.stb), 32'd0);
    chk("ar_sadr", s_bus.adr, 32'h0);
    chk("ar_m0ack", 32'(m0_bus.ack), 32'd0);
    chk("ar_m0dat", m0_bus.dat_r, 32'h0);
    s_bus.irq = 1'b1;
    #1;
    chk("ar_irq0_rst", 32'(m0_bus.irq), 32'd1);
    chk("ar_irq1_rst", 32'(m1_bus.irq), 32'd1);
    req_q0.delete();
    step_cyc();
    drop(0);
    idle_slave();
    rst = 1'b0;
    step_cyc();
    chk("ar_after_grant", 32'(o_grant), 32'(GNT_NONE));
    chk("ar_irq0", 32'(m0_bus.irq), 32'd1);
    chk("ar_irq1", 32'(m1_bus.irq), 32'd1);
    s_bus.irq = 1'b0;
    #1;
    chk("ar_irq0_low", 32'(m0_bus.irq), 32'd0);
    chk("sb_empty", 32'(req_q0.size() + req_q1.size() + rd_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
